// File: rtl/sync2drive_bridge.sv
// Clocked-to-self-timed entry stage: buffers producer words in a small FIFO and
// launches each into a drive/free bundled-data handshake. Optional watchdog: SYNC2DRIVE_TIMEOUT_EN.
module sync2drive_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned DRIVE_PULSE    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_drive,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_free,
  output logic                  o_busy,
  output logic                  o_spurious,
  output logic                  o_timeout
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CMAX  = (SETUP_CYCLES > DRIVE_PULSE) ? SETUP_CYCLES : DRIVE_PULSE;
  localparam int unsigned CW    = $clog2(CMAX + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SETUP_CYCLES < 1 ||
      DRIVE_PULSE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sync2drive_bridge: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, WAIT_FREE} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, count, count_next;
  logic                  push, pop, empty;
  logic                  free_p0, free_p1, free_p2, free_evt;
  logic                  tmo_hit;
  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;

  // FIFO: extra pointer bit distinguishes full from empty; write lands before it can be popped
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign push       = i_valid & o_ready;
  assign count_next = count + PW'(push) - PW'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_ready <= (count_next < PW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // i_free synchronizer (p0, p1) plus edge-detect history (p2)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_p0 <= 1'b0;
      free_p1 <= 1'b0;
      free_p2 <= 1'b0;
    end else begin
      free_p0 <= i_free;
      free_p1 <= free_p0;
      free_p2 <= free_p1;
    end
  end

  assign free_evt = free_p1 & ~free_p2;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
          cnt_next   = '0;
        end
      end
      SETUP: begin
        if (cnt == CW'(SETUP_CYCLES - 1)) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == CW'(DRIVE_PULSE - 1)) begin
          state_next = WAIT_FREE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_FREE: begin
        cnt_next = '0;
        if (free_evt) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end else if (tmo_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      o_drive    <= 1'b0;
      o_busy     <= 1'b0;
      o_spurious <= 1'b0;
      o_data     <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      o_drive <= (state_next == DRIVE);
      o_busy  <= (state_next != IDLE);
      if (free_evt && state != WAIT_FREE) o_spurious <= 1'b1;
      if (pop) o_data <= mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef SYNC2DRIVE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // A free event on the final watchdog cycle still wins over the timeout
  assign tmo_hit = (state == WAIT_FREE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state == WAIT_FREE && !free_evt && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                                             tmo_cnt <= '0;
      if (tmo_hit && !free_evt) o_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule
